// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the write-back port arbiter and its result FIFO.
//   REG_W  : register-number width
//   DATA_W : register data width
//   R0     : the hard-wired zero register; writes to it are dropped
package wb_port_arbiter_pkg;
    localparam int              REG_W  = 5;
    localparam int              DATA_W = 32;
    localparam logic [REG_W-1:0] R0    = '0;
endpackage

// File: rtl/wb_result_fifo.sv
// MDU result FIFO. Each entry holds {valid, rn, data}. Entries can be
// invalidated in place by register number (WAW kill); an invalidated entry
// keeps its slot until it reaches the head and is popped.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   push, push_rn, push_data    : enqueue at tail (caller guarantees not full)
//   pop                         : drop head entry (caller guarantees not empty)
//   kill_en, kill_rn            : clear every valid entry with matching rn
//   rs, rt, match               : match = some valid non-r0 entry has rn==rs or rn==rt
//   head_valid/head_rn/head_data: head entry (head_valid=0 when empty)
//   count                       : number of occupied slots, 0..DEPTH
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_W-1:0]  push_rn,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_W-1:0]  kill_rn,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    output logic              match,
    output logic              head_valid,
    output logic [REG_W-1:0]  head_rn,
    output logic [DATA_W-1:0] head_data,
    output logic [AW:0]       count
);
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][REG_W-1:0]  rn;
    logic [DEPTH-1:0][DATA_W-1:0] data;
    logic [AW-1:0]                head, tail;

    // Later assignments win: kill, then pop clear, then push set. A push
    // landing on the same edge as a kill therefore survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill_en && vld[i] && rn[i] == kill_rn) vld[i] <= 1'b0;
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (push) begin
            rn[tail]   <= push_rn;
            data[tail] <= push_data;
        end
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && rn[i] != R0 && (rn[i] == rs || rn[i] == rt)) match = 1'b1;
    end

    assign head_valid = vld[head] && (count != '0);
    assign head_rn    = rn[head];
    assign head_data  = data[head];
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline WB stage and the MDU.
// The pipeline always owns the port; MDU results queue in a FIFO and drain
// on free cycles. Also produces RAW stall and drain request for the hazard unit.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   wb_wreg, wb_rn, wb_data       : pipeline write-back
//   mdu_valid, mdu_rn, mdu_data   : MDU result; mdu_ready = FIFO has room
//   id_rs, id_rt, raw_stall       : ID sources vs pending MDU results
//   drain_req                     : head waited too long or FIFO full
//   rf_we, rf_wn, rf_d            : register-file write port
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int AGE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [REG_W-1:0]  wb_rn,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    input  logic [REG_W-1:0]  mdu_rn,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    output logic              raw_stall,
    output logic              drain_req,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wn,
    output logic [DATA_W-1:0] rf_d
);
    localparam int               AGE_W    = $clog2(AGE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_TOP  = AGE_W'(AGE_MAX);
    localparam logic [AW:0]      CNT_FULL = (AW + 1)'(DEPTH);

    logic              pw, push, pop, nonempty;
    logic              head_valid;
    logic [REG_W-1:0]  head_rn;
    logic [DATA_W-1:0] head_data;
    logic [AW:0]       count, count_next;
    logic [AGE_W-1:0]  age, age_next;

    assign pw        = wb_wreg && (wb_rn != R0);
    assign mdu_ready = (count != CNT_FULL);
    // r0 results are accepted (handshake completes) but never stored.
    assign push      = mdu_valid && mdu_ready && (mdu_rn != R0);
    assign nonempty  = (count != '0);
    // Killed heads leave without using the port, so they go even under pw.
    assign pop       = nonempty && (!head_valid || !pw);

    wb_result_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rn   (mdu_rn),
        .push_data (mdu_data),
        .pop       (pop),
        .kill_en   (pw),
        .kill_rn   (wb_rn),
        .rs        (id_rs),
        .rt        (id_rt),
        .match     (raw_stall),
        .head_valid(head_valid),
        .head_rn   (head_rn),
        .head_data (head_data),
        .count     (count)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wn = R0;
        rf_d  = '0;
        if (!rst) begin
            if (pw) begin
                rf_we = 1'b1;
                rf_wn = wb_rn;
                rf_d  = wb_data;
            end else if (head_valid) begin
                rf_we = 1'b1;
                rf_wn = head_rn;
                rf_d  = head_data;
            end
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
        age_next = age;
        if (!nonempty || pop)                 age_next = '0;
        else if (head_valid && age != AGE_TOP) age_next = age + 1'b1;
    end

    // drain_req is registered from the next-state values so it tracks the
    // registered age/count exactly: set the cycle the limit is reached,
    // cleared the cycle after the head pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age       <= '0;
            drain_req <= 1'b0;
        end else begin
            age       <= age_next;
            drain_req <= (age_next == AGE_TOP) || (count_next == CNT_FULL);
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: reset checks, a table of directed cycles,
// a mid-operation reset, then randomized traffic against a queue model.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4, AW = 2, AGE_MAX = 8;

    logic        clk = 1'b0, rst;
    logic        wb_wreg, mdu_valid, mdu_ready, raw_stall, drain_req, rf_we;
    logic [4:0]  wb_rn, mdu_rn, id_rs, id_rt, rf_wn;
    logic [31:0] wb_data, mdu_data, rf_d;

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_rn(mdu_rn), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .id_rs(id_rs), .id_rt(id_rt),
        .raw_stall(raw_stall), .drain_req(drain_req),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic raw, input logic drn,
                           input logic we, input logic [4:0] wn, input logic [31:0] d);
        chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(rdy));
        chk({tag, ".raw_stall"}, 32'(raw_stall), 32'(raw));
        chk({tag, ".drain_req"}, 32'(drain_req), 32'(drn));
        chk({tag, ".rf_we"},     32'(rf_we),     32'(we));
        chk({tag, ".rf_wn"},     32'(rf_wn),     32'(wn));
        chk({tag, ".rf_d"},      rf_d,           d);
    endtask

    task automatic drive(input logic wr, input logic [4:0] wrn, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mrn, input logic [31:0] md,
                         input logic [4:0] rs, input logic [4:0] rt);
        wb_wreg = wr; wb_rn = wrn; wb_data = wd;
        mdu_valid = mv; mdu_rn = mrn; mdu_data = md;
        id_rs = rs; id_rt = rt;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: one record per cycle, inputs then expected outputs.
    typedef struct {
        logic        wr;  logic [4:0] wrn; logic [31:0] wd;
        logic        mv;  logic [4:0] mrn; logic [31:0] md;
        logic [4:0]  rs, rt;
        logic        rdy, raw, drn, we; logic [4:0] wn; logic [31:0] d;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic wr, input logic [4:0] wrn, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrn, input logic [31:0] md,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic rdy, input logic raw, input logic drn,
                       input logic we, input logic [4:0] wn, input logic [31:0] d);
        vec_t v;
        v.wr = wr; v.wrn = wrn; v.wd = wd; v.mv = mv; v.mrn = mrn; v.md = md;
        v.rs = rs; v.rt = rt; v.rdy = rdy; v.raw = raw; v.drn = drn;
        v.we = we; v.wn = wn; v.d = d;
        vecs.push_back(v);
    endtask

    // Reference model: pending MDU results in age order plus the head wait time.
    typedef struct { bit v; logic [4:0] rn; logic [31:0] d; } ent_t;
    ent_t mq[$];
    int   m_age;

    initial begin
        // single MDU result, 1-cycle latency
        add(0,0,0,     1,5,'h1234, 0,0,  1,0,0, 0,0,0);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 1,5,'h1234);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 0,0,0);
        // fill under continuous pipeline writes, then drain in order
        add(1,3,'h33,  1,10,'hA0,  0,0,  1,0,0, 1,3,'h33);
        add(1,3,'h33,  1,11,'hA1,  0,0,  1,0,0, 1,3,'h33);
        add(1,3,'h33,  1,12,'hA2,  0,0,  1,0,0, 1,3,'h33);
        add(1,3,'h33,  1,13,'hA3,  0,0,  1,0,0, 1,3,'h33);
        add(1,3,'h33,  1,14,'hA4,  0,0,  0,0,1, 1,3,'h33);
        add(0,0,0,     0,0,0,      13,0, 0,1,1, 1,10,'hA0);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 1,11,'hA1);
        add(0,0,0,     0,0,0,      0,14, 1,0,0, 1,12,'hA2);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 1,13,'hA3);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 0,0,0);
        // WAW kill
        add(0,0,0,     1,7,'h77,   0,0,  1,0,0, 0,0,0);
        add(1,7,'hAA,  0,0,0,      7,0,  1,1,0, 1,7,'hAA);
        add(0,0,0,     0,0,0,      7,0,  1,0,0, 0,0,0);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 0,0,0);
        // WAW kill with same-edge enqueue of the same rn
        add(0,0,0,     1,7,'h71,   0,0,  1,0,0, 0,0,0);
        add(1,7,'hAB,  1,7,'h72,   0,0,  1,0,0, 1,7,'hAB);
        add(0,0,0,     0,0,0,      0,7,  1,1,0, 0,0,0);
        add(0,0,0,     0,0,0,      0,7,  1,1,0, 1,7,'h72);
        add(0,0,0,     0,0,0,      0,7,  1,0,0, 0,0,0);
        // RAW stall; r0 results never stored
        add(1,4,'h44,  1,9,'h99,   0,0,  1,0,0, 1,4,'h44);
        add(1,4,'h44,  0,0,0,      9,0,  1,1,0, 1,4,'h44);
        add(0,0,0,     0,0,0,      9,0,  1,1,0, 1,9,'h99);
        add(0,0,0,     0,0,0,      9,0,  1,0,0, 0,0,0);
        add(0,0,0,     1,0,'h55,   0,0,  1,0,0, 0,0,0);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 0,0,0);
        // pipeline write to r0 leaves the port to the FIFO head
        add(0,0,0,     1,2,'h22,   0,0,  1,0,0, 0,0,0);
        add(1,0,'hDEAD,0,0,0,      0,0,  1,0,0, 1,2,'h22);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 0,0,0);
        // starvation: head held AGE_MAX cycles
        add(0,0,0,     1,20,'hC0,  0,0,  1,0,0, 0,0,0);
        for (int i = 0; i < AGE_MAX; i++)
            add(1,3,'h33, 0,0,0,   0,0,  1,0,0, 1,3,'h33);
        add(1,3,'h33,  0,0,0,      0,0,  1,0,1, 1,3,'h33);
        add(0,0,0,     0,0,0,      0,0,  1,0,1, 1,20,'hC0);
        add(0,0,0,     0,0,0,      0,0,  1,0,0, 0,0,0);

        // reset with traffic present: outputs forced, nothing enqueued
        rst = 1'b1;
        drive(1,3,'h33, 1,5,'h1234, 5,0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk) chk_all("in_reset", 1,0,0,0,0,0);
        step();
        rst = 1'b0;
        drive(0,0,0, 0,0,0, 5,0);
        @(negedge clk) chk_all("post_reset", 1,0,0,0,0,0);
        step();

        foreach (vecs[k]) begin
            drive(vecs[k].wr, vecs[k].wrn, vecs[k].wd, vecs[k].mv, vecs[k].mrn, vecs[k].md,
                  vecs[k].rs, vecs[k].rt);
            @(negedge clk) chk_all($sformatf("vec%0d", k), vecs[k].rdy, vecs[k].raw,
                                   vecs[k].drn, vecs[k].we, vecs[k].wn, vecs[k].d);
            step();
        end

        // reset mid-operation discards pending entries
        drive(1,3,'h33, 1,6,'h66, 0,0);
        step();
        drive(1,3,'h33, 1,8,'h88, 6,8);
        @(negedge clk) chk_all("pre_rst", 1,1,0,1,3,'h33);
        step();
        rst = 1'b1;
        drive(1,3,'h33, 1,9,'h99, 6,8);
        @(negedge clk) chk_all("mid_rst", 1,0,0,0,0,0);
        step();
        rst = 1'b0;
        drive(0,0,0, 0,0,0, 6,8);
        @(negedge clk) chk_all("after_rst", 1,0,0,0,0,0);
        step();

        // randomized traffic against the queue model
        mq.delete();
        m_age = 0;
        for (int i = 0; i < 3000; i++) begin
            int   wpct;
            bit   pw, popped, acc, was_empty, head_v;
            logic e_rdy, e_raw, e_drn, e_we;
            logic [4:0]  e_wn;
            logic [31:0] e_d;
            ent_t ne;
            wpct = (i / 300) % 3 == 0 ? 30 : ((i / 300) % 3 == 1 ? 70 : 95);
            drive($urandom_range(99) < wpct, 5'($urandom_range(7)), $urandom,
                  $urandom_range(1), 5'($urandom_range(7)), $urandom,
                  5'($urandom_range(7)), 5'($urandom_range(7)));

            pw    = wb_wreg && wb_rn != 0;
            e_rdy = mq.size() != DEPTH;
            e_raw = 1'b0;
            foreach (mq[j])
                if (mq[j].v && mq[j].rn != 0 && (mq[j].rn == id_rs || mq[j].rn == id_rt))
                    e_raw = 1'b1;
            e_drn = (m_age == AGE_MAX) || (mq.size() == DEPTH);
            e_we = 1'b0; e_wn = '0; e_d = '0;
            if (pw) begin
                e_we = 1'b1; e_wn = wb_rn; e_d = wb_data;
            end else if (mq.size() > 0 && mq[0].v) begin
                e_we = 1'b1; e_wn = mq[0].rn; e_d = mq[0].d;
            end
            @(negedge clk) chk_all($sformatf("rand%0d", i), e_rdy, e_raw, e_drn, e_we, e_wn, e_d);

            was_empty = mq.size() == 0;
            head_v    = !was_empty && mq[0].v;
            popped    = !was_empty && (!mq[0].v || !pw);
            acc       = e_rdy && mdu_valid && mdu_rn != 0;
            if (pw)
                foreach (mq[j]) if (mq[j].v && mq[j].rn == wb_rn) mq[j].v = 1'b0;
            if (popped) void'(mq.pop_front());
            if (acc) begin
                ne.v = 1'b1; ne.rn = mdu_rn; ne.d = mdu_data;
                mq.push_back(ne);
            end
            if (was_empty || popped) m_age = 0;
            else if (head_v && m_age < AGE_MAX) m_age++;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back (ALU/memory result after the WB mux) and the multi-cycle multiply/divide unit (MDU).
- The pipeline always wins the port. MDU results are buffered in a small FIFO and drained on free port cycles.
- Also provides RAW stall, WAW kill and starvation-drain control to the hazard unit.
- Sits between the WB stage, the MDU and the register file.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of 2, ≥2)
- AW, 2, log2(DEPTH)
- AGE_MAX, 8, cycles a valid head may wait before a drain request

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_wreg  in  1  pipeline WB write enable
- wb_rn  in  5  pipeline WB destination register
- wb_data  in  32  pipeline WB data (WB mux output)
- mdu_valid  in  1  MDU result available
- mdu_rn  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  FIFO can accept this cycle
- id_rs  in  5  ID-stage source register 1
- id_rt  in  5  ID-stage source register 2
- raw_stall  out  1  ID source matches a valid pending FIFO entry
- drain_req  out  1  hazard unit must inject WB bubbles
- rf_we  out  1  register-file write enable
- rf_wn  out  5  register-file write address
- rf_d  out  32  register-file write data

Behaviour:
- Reset is asynchronous, active-high. It clears: head/tail pointers, count, all entry valid bits and the age counter.
- Port states while in reset: mdu_ready=1, raw_stall=0, drain_req=0, rf_we=0.
- Pipeline write (pw) = wb_wreg & (wb_rn≠0). A pipeline write to r0 leaves the port free.
- Port selection (combinational, same cycle):
  - If pw: rf_we=1, rf_wn=wb_rn, rf_d=wb_data.
  - Else if FIFO non-empty and the head is valid: write the head entry and pop it.
  - Else: rf_we=0, rf_wn=0, rf_d=0.
- An invalid (killed) head is popped in any cycle without using the port. This applies even when pw=1.
- Enqueue:
  - mdu_ready = (count≠DEPTH), decided from registered count only. A same-cycle pop does not free a slot for that cycle's enqueue.
  - The MDU result is accepted when mdu_valid & mdu_ready.
  - Accepted entries with mdu_rn=0 are not stored.
  - Minimum MDU latency to rf_we is 1 cycle; there is no bypass.
- Count update: +1 on enqueue only, −1 on pop only, unchanged when both happen. Pointers wrap modulo DEPTH.
- WAW kill: when pw=1, every valid FIFO entry with rn==wb_rn is cleared the same edge, because the younger pipeline write supersedes it.
  - An entry enqueued on that same edge with the same rn is NOT killed. The MDU result is younger.
- RAW: raw_stall=1 if any valid entry has rn==id_rs or rn==id_rt, with rn≠0. Purely combinational on current contents.
- Age counter:
  - Increments each cycle the head is valid and not popped.
  - Resets to 0 on pop or when the FIFO is empty. Saturates at AGE_MAX.
  - drain_req = (age==AGE_MAX) | (count==DEPTH). Registered, asserted the cycle after the condition, held until the condition clears.
- Reset mid-operation discards all pending entries. The MDU must reissue.

Decomposition:
- Shared package: REG_W=5, DATA_W=32, and a constant for register r0. No typedefs needed.
- One natural sub-module: wb_result_fifo. It holds per-entry {valid, rn, data}, pointers and count, with kill-by-rn and match-by-rn ports.
- The arbiter owns port muxing, age counting and drain_req.

Test Plan:
- Reset with mdu_valid=1 → mdu_ready=1, rf_we=0, raw_stall=0, drain_req=0. Nothing is enqueued while rst=1.
- FIFO empty, wb_wreg=0; MDU gives rn=5, data=0x1234 at cycle 0 → rf_we=1, rf_wn=5, rf_d=0x1234 at cycle 1. count returns to 0.
- wb_wreg=1 every cycle (rn=3) with 4 MDU results enqueued:
  - mdu_ready=0 after the 4th.
  - drain_req=1 the next cycle.
  - The first cycle wb_wreg=0, the head (oldest) is written.
- FIFO holds rn=7; pipeline writes wb_rn=7, data=0xAA → rf_d=0xAA. The entry is killed and popped later without rf_we.
  - The same case with a simultaneous MDU enqueue of rn=7 keeps the new entry.
- FIFO holds rn=9; id_rs=9 → raw_stall=1. id_rs=0 with a stored r0 entry is impossible; an mdu_rn=0 result is not stored and raw_stall stays 0.
- Single entry held AGE_MAX cycles by continuous pipeline writes → drain_req=1 on cycle AGE_MAX+1. It deasserts the cycle after the head pops.
